debug_dump_scheduler: RTL and testbench
=======================================

DEBUG_DUMP_SCHEDULER -- requirements
Module: debug_dump_scheduler

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all logic on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have ports: step_pulse, pc_inst_trigger, reg_trigger, alu_trigger  input  1 each  single-cycle request pulses from button controller.
REQ-004 SHALL have ports: pc, instruction, reg_value, alu_result  input  32 each  core state to dump.
REQ-005 SHALL have port: tx_busy  input  1  shared UART transmitter busy.
REQ-006 SHALL have ports: tx_start  output  1  one-cycle byte launch; tx_data  output  8  byte to send.
REQ-007 SHALL have ports: core_step  output  1  one-cycle core advance pulse; dump_active  output  1  high in any state except IDLE.

Function
REQ-008 SHALL latch each trigger into its own pending flag; a repeat trigger while the flag is set is absorbed.
REQ-009 SHALL grant pending dumps with fixed priority pc_inst > reg > alu, one message at a time.
REQ-010 SHALL use states IDLE, GRANT, SEND, WAIT, DONE; IDLE->GRANT when any flag set; GRANT->SEND; SEND->WAIT on tx_start; WAIT->SEND if bytes remain, else ->DONE; DONE->IDLE.
REQ-011 SHALL, in GRANT, snapshot the granted source's 32-bit value(s) into a holding register and clear that pending flag; a trigger for the same source on or after the GRANT cycle re-sets the flag.
REQ-012 SHALL frame messages as tag byte, data bytes MSB first, then 0x0A; tags: pc_inst 0x50 (pc, then instruction), reg 0x52, alu 0x41.
REQ-013 SHALL, in SEND, assert tx_start for exactly one cycle with tx_data valid only when tx_busy=0; otherwise hold in SEND.
REQ-014 SHALL, in WAIT, ignore tx_busy in the first cycle and leave WAIT only after tx_busy=0.
REQ-015 SHALL hold tx_data stable from tx_start until the next byte's launch.
REQ-016 SHALL, in IDLE with no pending dump, issue core_step the cycle after step_pulse (latency 1).
REQ-017 SHALL, when step_pulse arrives while dump_active=1 or a dump is pending, set a one-deep step-pending flag (further pulses absorbed), and issue core_step in the DONE cycle of the last queued dump.
REQ-018 SHALL, on simultaneous step_pulse and trigger in IDLE, dump first (pre-step state), then step.
REQ-019 SHALL never assert core_step and tx_start in the same cycle except as permitted by REQ-017.

Reset
REQ-020 SHALL, with reset=1 at a clock edge, enter IDLE and clear pending flags, step-pending, byte counter, holding register.
REQ-021 SHALL drive tx_start=0, tx_data=0x00, core_step=0, dump_active=0 during and after reset until a request.
REQ-022 SHALL abandon a message mid-transfer on reset with no further tx_start.

Configuration
REQ-023 SHALL support macro DUMP_HEX_EN.
REQ-024 SHALL, with DUMP_HEX_EN defined, send each data byte as two uppercase ASCII hex chars, high nibble first (pc_inst 18 bytes, reg/alu 10 bytes incl. tag and 0x0A).
REQ-025 SHALL, without DUMP_HEX_EN, send raw data bytes (pc_inst 10 bytes, reg/alu 6 bytes).

Verification
REQ-026 SHALL cover: raw build, alu_result=0xDEADBEEF, alu_trigger, tx_busy 3 cycles after each start -> bytes 0x41,DE,AD,BE,EF,0A.
REQ-027 SHALL cover: hex build, reg_value=0x0000A5F1, reg_trigger -> bytes "R","0","0","0","0","A","5","F","1",0x0A.
REQ-028 SHALL cover: alu, reg, pc_inst triggers same cycle -> messages sequenced pc_inst (0x50), reg (0x52), alu (0x41); no byte interleaving.
REQ-029 SHALL cover: step_pulse mid-dump twice -> exactly one core_step, in DONE cycle; step_pulse in idle -> core_step 1 cycle later.
REQ-030 SHALL cover: pc=0x00000100, pc_inst_trigger, pc changed next cycle to 0x00000104 -> message carries 0x00000100; reset after 3rd byte -> IDLE, no tx_start.

Source files
------------

// File: rtl/debug_dump_scheduler.sv
// Debug dump scheduler: queues dump requests and streams framed messages to a shared UART.
// It also sequences core single-step pulses around the dumps. Define DUMP_HEX_EN to send ASCII hex instead of raw bytes.
module debug_dump_scheduler (
   input  logic        clk,
   input  logic        reset,
   input  logic        step_pulse,
   input  logic        pc_inst_trigger,
   input  logic        reg_trigger,
   input  logic        alu_trigger,
   input  logic [31:0] pc,
   input  logic [31:0] instruction,
   input  logic [31:0] reg_value,
   input  logic [31:0] alu_result,
   input  logic        tx_busy,
   output logic        tx_start,
   output logic [7:0]  tx_data,
   output logic        core_step,
   output logic        dump_active
);

   // A data unit is one nibble in hex mode or one whole byte in raw mode.
`ifdef DUMP_HEX_EN
   localparam int UNIT_BITS = 4;
`else
   localparam int UNIT_BITS = 8;
`endif
   localparam logic [4:0] LAST_PC   = 5'(64 / UNIT_BITS + 1);
   localparam logic [4:0] LAST_WORD = 5'(32 / UNIT_BITS + 1);

   typedef enum logic [2:0] {IDLE, GRANT, SEND, WAIT, DONE} state_t;
   typedef enum logic [1:0] {SRC_PC, SRC_REG, SRC_ALU} src_t;

   state_t state;
   src_t   src;
   logic   pend_pc, pend_reg, pend_alu, step_pend, wait_first;
   logic [4:0]  byte_idx;
   logic [63:0] hold;
   logic [4:0]  msg_last;
   logic [4:0]  unit_idx;
   logic [5:0]  unit_base;
   logic [UNIT_BITS-1:0] unit;
   logic [7:0]  cur_byte;
   logic        any_pend, any_trig;

   assign any_pend = pend_pc | pend_reg | pend_alu;
   assign any_trig = pc_inst_trigger | reg_trigger | alu_trigger;
   assign msg_last = (src == SRC_PC) ? LAST_PC : LAST_WORD;

   // Holding register is left-aligned so every message walks it from bit 63 down.
   always_comb begin
      unit_idx  = byte_idx - 5'd1;
      unit_base = 6'(63 - UNIT_BITS * int'(unit_idx));
      unit      = hold[unit_base -: UNIT_BITS];
      cur_byte  = 8'h00;
      if (byte_idx == 5'd0) begin
         case (src)
            SRC_PC:  cur_byte = 8'h50;
            SRC_REG: cur_byte = 8'h52;
            default: cur_byte = 8'h41;
         endcase
      end else if (byte_idx == msg_last) begin
         cur_byte = 8'h0A;
      end else begin
`ifdef DUMP_HEX_EN
         cur_byte = (unit < 4'd10) ? {4'h3, unit} : (8'h37 + {4'h0, unit});
`else
         cur_byte = unit;
`endif
      end
   end

   // Request latching, grant arbitration, byte streaming and step sequencing.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         src         <= SRC_PC;
         pend_pc     <= 1'b0;
         pend_reg    <= 1'b0;
         pend_alu    <= 1'b0;
         step_pend   <= 1'b0;
         wait_first  <= 1'b0;
         byte_idx    <= 5'd0;
         hold        <= 64'd0;
         tx_start    <= 1'b0;
         tx_data     <= 8'h00;
         core_step   <= 1'b0;
         dump_active <= 1'b0;
      end else begin
         tx_start  <= 1'b0;
         core_step <= 1'b0;
         if (pc_inst_trigger) pend_pc  <= 1'b1;
         if (reg_trigger)     pend_reg <= 1'b1;
         if (alu_trigger)     pend_alu <= 1'b1;
         if (step_pulse) begin
            if (state == IDLE && !any_pend && !any_trig) core_step <= 1'b1;
            else step_pend <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (any_pend) begin
                  state       <= GRANT;
                  dump_active <= 1'b1;
               end else if (step_pend && !any_trig) begin
                  core_step <= 1'b1;
                  step_pend <= 1'b0;
               end
            end
            GRANT: begin
               byte_idx <= 5'd0;
               state    <= SEND;
               if (pend_pc) begin
                  src     <= SRC_PC;
                  hold    <= {pc, instruction};
                  pend_pc <= pc_inst_trigger;
               end else if (pend_reg) begin
                  src      <= SRC_REG;
                  hold     <= {reg_value, 32'd0};
                  pend_reg <= reg_trigger;
               end else begin
                  src      <= SRC_ALU;
                  hold     <= {alu_result, 32'd0};
                  pend_alu <= alu_trigger;
               end
            end
            SEND: begin
               if (!tx_busy) begin
                  tx_start   <= 1'b1;
                  tx_data    <= cur_byte;
                  byte_idx   <= byte_idx + 5'd1;
                  wait_first <= 1'b1;
                  state      <= WAIT;
               end
            end
            WAIT: begin
               wait_first <= 1'b0;
               if (!wait_first && !tx_busy) begin
                  if (byte_idx <= msg_last) begin
                     state <= SEND;
                  end else begin
                     state <= DONE;
                     if (step_pend && !any_pend && !any_trig) begin
                        core_step <= 1'b1;
                        step_pend <= 1'b0;
                     end
                  end
               end
            end
            default: begin
               state       <= IDLE;
               dump_active <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_debug_dump_scheduler.sv
// Randomized self-checking bench for debug_dump_scheduler; expected bytes come from a message-level model.
// Build with DUMP_HEX_EN defined to exercise the ASCII hex format.
module tb_debug_dump_scheduler;

   logic        clk = 1'b0;
   logic        reset;
   logic        step_pulse, pc_inst_trigger, reg_trigger, alu_trigger;
   logic [31:0] pc, instruction, reg_value, alu_result;
   logic        tx_busy;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        core_step;
   logic        dump_active;

   debug_dump_scheduler dut (
      .clk(clk), .reset(reset), .step_pulse(step_pulse),
      .pc_inst_trigger(pc_inst_trigger), .reg_trigger(reg_trigger), .alu_trigger(alu_trigger),
      .pc(pc), .instruction(instruction), .reg_value(reg_value), .alu_result(alu_result),
      .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
      .core_step(core_step), .dump_active(dump_active)
   );

   always #5 clk = ~clk;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];
   int         busy_len = 3;
   bit         busy_noise = 1'b0;
   int         step_count = 0;
   logic       step_active = 1'b0;
   int         step_bytes = 0;
   int         tx_count = 0;
   logic [7:0] last_data = 8'h00;

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // UART stand-in: busy for busy_len cycles after each launch, plus optional random stalls.
   initial begin
      int cnt;
      cnt = 0;
      tx_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (tx_start === 1'b1) cnt = busy_len;
         tx_busy = (cnt > 0) || (busy_noise && $urandom_range(0, 3) == 0);
         if (cnt > 0) cnt--;
      end
   end

   // Byte capture plus per-cycle invariants on tx_data stability and step/launch exclusivity.
   initial begin
      forever begin
         @(negedge clk);
         if (reset !== 1'b0) begin
            last_data = 8'h00;
         end else begin
            if (tx_start) begin
               got_q.push_back(tx_data);
               last_data = tx_data;
               tx_count++;
               checkOutput("step_with_tx", {63'd0, core_step}, 64'd0);
            end else begin
               checkOutput("tx_data_hold", {56'd0, tx_data}, {56'd0, last_data});
            end
            if (core_step) begin
               step_count++;
               step_active = dump_active;
               step_bytes  = got_q.size();
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Pulse bits are {step, pc_inst, reg, alu} for one cycle.
   task automatic applyStimulus(input logic [3:0] p);
      {step_pulse, pc_inst_trigger, reg_trigger, alu_trigger} = p;
      tick(1);
      {step_pulse, pc_inst_trigger, reg_trigger, alu_trigger} = 4'b0000;
   endtask

   task automatic waitIdle(input int budget);
      int quiet, n;
      quiet = 0;
      n = 0;
      while (quiet < 4 && n < budget) begin
         @(negedge clk);
         n++;
         if (dump_active) quiet = 0;
         else quiet++;
      end
      if (quiet < 4) checkOutput("idle_timeout", 64'd1, 64'd0);
      tick(1);
   endtask

   task automatic waitActive(input int budget);
      int n;
      n = 0;
      while (dump_active !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (dump_active !== 1'b1) checkOutput("active_timeout", 64'd0, 64'd1);
   endtask

   task automatic pushWord(input logic [31:0] w);
`ifdef DUMP_HEX_EN
      for (int i = 7; i >= 0; i--) begin
         int nib;
         nib = int'((w >> (4 * i)) & 32'hF);
         exp_q.push_back(nib < 10 ? 8'(48 + nib) : 8'(55 + nib));
      end
`else
      for (int i = 3; i >= 0; i--) exp_q.push_back(8'((w >> (8 * i)) & 32'hFF));
`endif
   endtask

   // Reference message: tag, value(s) most significant first, newline.
   task automatic pushMsg(input int src, input logic [31:0] a, input logic [31:0] b);
      exp_q.push_back(src == 0 ? 8'h50 : (src == 1 ? 8'h52 : 8'h41));
      pushWord(a);
      if (src == 0) pushWord(b);
      exp_q.push_back(8'h0A);
   endtask

   task automatic checkBytes(input string tag);
      checkOutput({tag, "_len"}, 64'(got_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         checkOutput($sformatf("%s_b%0d", tag, i), {56'd0, got_q[i]}, {56'd0, exp_q[i]});
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      int s0, t0, len, n;
      logic [31:0] old_alu;
      reset = 1'b1;
      {step_pulse, pc_inst_trigger, reg_trigger, alu_trigger} = 4'b0000;
      pc = 32'd0; instruction = 32'd0; reg_value = 32'd0; alu_result = 32'd0;
      tick(2);
      @(negedge clk);
      checkOutput("rst_tx_start", {63'd0, tx_start}, 64'd0);
      checkOutput("rst_tx_data", {56'd0, tx_data}, 64'd0);
      checkOutput("rst_core_step", {63'd0, core_step}, 64'd0);
      checkOutput("rst_dump_active", {63'd0, dump_active}, 64'd0);
      tick(1);
      reset = 1'b0;
      tick(5);
      checkOutput("post_rst_active", {63'd0, dump_active}, 64'd0);
      checkOutput("post_rst_txcount", 64'(tx_count), 64'd0);

`ifdef DUMP_HEX_EN
      reg_value = 32'h0000A5F1;
      applyStimulus(4'b0010);
      waitIdle(2000);
      exp_q = '{8'h52, 8'h30, 8'h30, 8'h30, 8'h30, 8'h41, 8'h35, 8'h46, 8'h31, 8'h0A};
      checkBytes("reg_hex");
`else
      alu_result = 32'hDEADBEEF;
      applyStimulus(4'b0001);
      waitIdle(2000);
      exp_q = '{8'h41, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h0A};
      checkBytes("alu_raw");
`endif

      // Same-cycle triggers must come out in priority order, one whole message at a time.
      pc = $urandom; instruction = $urandom; reg_value = $urandom; alu_result = $urandom;
      applyStimulus(4'b0111);
      waitIdle(3000);
      pushMsg(0, pc, instruction);
      pushMsg(1, reg_value, 32'd0);
      pushMsg(2, alu_result, 32'd0);
      checkBytes("priority");

      // A retrigger during the grant cycle queues a second message with the new value.
      old_alu = $urandom;
      alu_result = old_alu;
      alu_trigger = 1'b1;
      tick(1);
      alu_trigger = 1'b0;
      waitActive(50);
      alu_trigger = 1'b1;
      @(posedge clk);
      #1;
      alu_trigger = 1'b0;
      alu_result = ~old_alu;
      waitIdle(3000);
      pushMsg(2, old_alu, 32'd0);
      pushMsg(2, ~old_alu, 32'd0);
      checkBytes("grant_retrigger");

      // Two step requests during a dump collapse into one step in the DONE cycle.
      s0 = step_count;
      alu_result = $urandom;
      applyStimulus(4'b0001);
      waitActive(50);
      tick(3);
      applyStimulus(4'b1000);
      tick(4);
      applyStimulus(4'b1000);
      waitIdle(2000);
      pushMsg(2, alu_result, 32'd0);
      len = exp_q.size();
      checkBytes("mid_step_msg");
      checkOutput("mid_step_count", 64'(step_count - s0), 64'd1);
      checkOutput("mid_step_in_dump", {63'd0, step_active}, 64'd1);
      checkOutput("mid_step_after_bytes", 64'(step_bytes), 64'(len));

      // Step request in idle produces core_step exactly one cycle later.
      s0 = step_count;
      step_pulse = 1'b1;
      @(negedge clk);
      checkOutput("idle_step_early", {63'd0, core_step}, 64'd0);
      @(posedge clk);
      #1;
      step_pulse = 1'b0;
      @(negedge clk);
      checkOutput("idle_step_latency", {63'd0, core_step}, 64'd1);
      tick(3);
      checkOutput("idle_step_count", 64'(step_count - s0), 64'd1);

      // Step and trigger together: dump the pre-step state first, then step.
      s0 = step_count;
      reg_value = $urandom;
      applyStimulus(4'b1010);
      waitIdle(2000);
      pushMsg(1, reg_value, 32'd0);
      len = exp_q.size();
      checkBytes("step_and_dump_msg");
      checkOutput("step_and_dump_count", 64'(step_count - s0), 64'd1);
      checkOutput("step_and_dump_order", 64'(step_bytes), 64'(len));

      // Source value changing after the grant must not leak into the message.
      pc = 32'h00000100;
      instruction = $urandom;
      applyStimulus(4'b0100);
      waitActive(50);
      @(posedge clk);
      #1;
      pc = 32'h00000104;
      waitIdle(3000);
      pushMsg(0, 32'h00000100, instruction);
      checkBytes("pc_snapshot");

      // Reset after the third byte abandons the message and drops queued work.
      pc = 32'h00000100;
      s0 = step_count;
      t0 = tx_count;
      applyStimulus(4'b0100);
      waitActive(50);
      tick(1);
      applyStimulus(4'b1010);
      n = 0;
      while (tx_count - t0 < 3 && n < 500) begin
         @(negedge clk);
         n++;
      end
      checkOutput("third_byte_seen", 64'(tx_count - t0), 64'd3);
      @(posedge clk);
      #1;
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      tick(60);
      checkOutput("abort_txcount", 64'(tx_count - t0), 64'd3);
      checkOutput("abort_active", {63'd0, dump_active}, 64'd0);
      checkOutput("abort_tx_data", {56'd0, tx_data}, 64'd0);
      checkOutput("abort_no_step", 64'(step_count - s0), 64'd0);
      pushMsg(0, 32'h00000100, instruction);
      while (exp_q.size() > 3) void'(exp_q.pop_back());
      checkBytes("abort_prefix");

      // Random trigger sets, values, UART latencies and stalls against the model.
      busy_noise = 1'b1;
      for (int it = 0; it < 12; it++) begin
         logic [2:0] m;
         m = 3'($urandom_range(1, 7));
         pc = $urandom; instruction = $urandom; reg_value = $urandom; alu_result = $urandom;
         busy_len = $urandom_range(0, 4);
         applyStimulus({1'b0, m});
         if ($urandom_range(0, 1) == 1) applyStimulus({1'b0, m});
         waitIdle(4000);
         if (m[2]) pushMsg(0, pc, instruction);
         if (m[1]) pushMsg(1, reg_value, 32'd0);
         if (m[0]) pushMsg(2, alu_result, 32'd0);
         checkBytes($sformatf("rand%0d", it));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
